// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encoding and helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package usr_pkg;

  localparam int USR_MODE_W = 3;

  typedef enum logic [USR_MODE_W-1:0] {
    USR_HOLD  = 3'd0,
    USR_LOAD  = 3'd1,
    USR_SHL   = 3'd2,
    USR_SHR   = 3'd3,
    USR_ASHR  = 3'd4,
    USR_ROTL  = 3'd5,
    USR_ROTR  = 3'd6,
    USR_CLEAR = 3'd7
  } usr_mode_t;

  // True for every mode whose result depends on amt (shifts and rotates).
  function automatic logic is_shift_mode(input usr_mode_t m);
    return (m == USR_SHL) || (m == USR_SHR) || (m == USR_ASHR) ||
           (m == USR_ROTL) || (m == USR_ROTR);
  endfunction

endpackage

// File: rtl/usr_shifter.sv
// Combinational shift/rotate datapath producing the candidate next register value.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; non-shift modes pass q through unchanged.
module usr_shifter
  import usr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         q,
  input  usr_mode_t            mode,
  input  logic [$clog2(N)-1:0] amt,
  input  logic                 sin_l,
  input  logic                 sin_r,
  output logic [N-1:0]         nxt
);

  logic [31:0]    amt32;
  logic [31:0]    k;     // shift distance, saturated at N
  logic [31:0]    r;     // rotate distance, amt mod N
  logic [2*N-1:0] wide;

  // Shifts run on a double-width word whose spare half holds the fill bits, so a
  // distance of N naturally yields all-fill; saturation only matters when N is not
  // a power of two, since otherwise amt can never reach N.
  always_comb begin
    amt32 = 32'(amt);
    k     = (amt32 >= 32'(N)) ? 32'(N) : amt32;
    r     = amt32 % 32'(N);
    wide  = {q, q};
    nxt   = q;
    case (mode)
      USR_SHL: begin
        wide = {q, {N{sin_r}}} << k;
        nxt  = wide[2*N-1:N];
      end
      USR_SHR: begin
        wide = {{N{sin_l}}, q} >> k;
        nxt  = wide[N-1:0];
      end
      USR_ASHR: begin
        wide = {{N{q[N-1]}}, q} >> k;
        nxt  = wide[N-1:0];
      end
      USR_ROTL: begin
        wide = {q, q} << r;
        nxt  = wide[2*N-1:N];
      end
      USR_ROTR: begin
        wide = {q, q} >> r;
        nxt  = wide[N-1:0];
      end
      default: nxt = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold/load/shift/arith-shift/rotate/clear with status flags.
// Latency: 1 cycle from inputs to q; flags are combinational from q only.
// Backpressure: none; en=0 holds. Macro USR_PARITY_EN enables the parity XOR tree.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [2:0]           mode,
  input  logic [$clog2(N)-1:0] amt,
  input  logic [N-1:0]         d,
  input  logic                 sin_l,
  input  logic                 sin_r,
  output logic [N-1:0]         q,
  output logic                 sout_l,
  output logic                 sout_r,
  output logic                 zero,
  output logic                 parity
);

  usr_mode_t    m;
  logic [N-1:0] shf_nxt;
  logic [N-1:0] q_nxt;

  assign m = usr_mode_t'(mode);

  usr_shifter #(.N(N)) u_shifter (
    .q     (q),
    .mode  (m),
    .amt   (amt),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .nxt   (shf_nxt)
  );

  // Select the next register value; a zero amount in a shift/rotate mode is a hold.
  always_comb begin
    q_nxt = q;
    if (en) begin
      case (m)
        USR_LOAD:  q_nxt = d;
        USR_CLEAR: q_nxt = '0;
        default: begin
          if (is_shift_mode(m) && (amt != '0)) q_nxt = shf_nxt;
        end
      endcase
    end
  end

  // Register state; reset clears immediately and drops any pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_nxt;
  end

  assign sout_l = q[N-1];
  assign sout_r = q[0];
  assign zero   = (q == '0);

`ifdef USR_PARITY_EN
  assign parity = ^q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register at N=8.
// Latency: checks q and flags 1 ns after each rising edge.
// Backpressure: not applicable; free-running clock with a global timeout.
module tb_universal_shift_register;
  import usr_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [2:0]   mode;
  logic [2:0]   amt;
  logic [N-1:0] d;
  logic         sin_l;
  logic         sin_r;
  logic [N-1:0] q;
  logic         sout_l, sout_r, zero, parity;

  int ntests = 0;
  int nfail  = 0;

  universal_shift_register #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .amt    (amt),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .zero   (zero),
    .parity (parity)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (ran %0d, failed %0d)", ntests, nfail);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic      en;
    usr_mode_t mode;
    logic [2:0] amt;
    logic [7:0] d;
    logic      sin_l;
    logic      sin_r;
    logic [7:0] exp_q;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic exp_parity(input logic [7:0] v);
`ifdef USR_PARITY_EN
    return ^v;
`else
    return 1'b0 & v[0];
`endif
  endfunction

  task automatic chk_all(input string nm, input logic [7:0] e);
    chk({nm, ".q"},      q,             e);
    chk({nm, ".sout_l"}, {7'd0, sout_l}, {7'd0, e[7]});
    chk({nm, ".sout_r"}, {7'd0, sout_r}, {7'd0, e[0]});
    chk({nm, ".zero"},   {7'd0, zero},   {7'd0, (e == 8'h00)});
    chk({nm, ".parity"}, {7'd0, parity}, {7'd0, exp_parity(e)});
  endtask

  task automatic drive(input vec_t v);
    en    = v.en;
    mode  = v.mode;
    amt   = v.amt;
    d     = v.d;
    sin_l = v.sin_l;
    sin_r = v.sin_r;
  endtask

  initial begin
    logic [7:0] e;

    // {en, mode, amt, d, sin_l, sin_r, expected q}; rows run back to back
    vecs.push_back('{1'b1, USR_LOAD,  3'd0, 8'h81, 1'b0, 1'b0, 8'h81});
    vecs.push_back('{1'b1, USR_SHL,   3'd1, 8'h00, 1'b0, 1'b1, 8'h03});
    vecs.push_back('{1'b1, USR_LOAD,  3'd0, 8'h90, 1'b0, 1'b0, 8'h90});
    vecs.push_back('{1'b1, USR_ASHR,  3'd3, 8'h00, 1'b0, 1'b0, 8'hF2});
    vecs.push_back('{1'b1, USR_LOAD,  3'd0, 8'h90, 1'b1, 1'b1, 8'h90});
    vecs.push_back('{1'b1, USR_SHR,   3'd3, 8'h00, 1'b0, 1'b1, 8'h12});
    vecs.push_back('{1'b1, USR_LOAD,  3'd0, 8'h81, 1'b0, 1'b0, 8'h81});
    vecs.push_back('{1'b1, USR_ROTR,  3'd1, 8'h00, 1'b1, 1'b1, 8'hC0});
    vecs.push_back('{1'b1, USR_LOAD,  3'd0, 8'h01, 1'b0, 1'b0, 8'h01});
    vecs.push_back('{1'b1, USR_ROTL,  3'd7, 8'h00, 1'b0, 1'b0, 8'h80});
    vecs.push_back('{1'b0, USR_LOAD,  3'd0, 8'hFF, 1'b1, 1'b1, 8'h80});
    vecs.push_back('{1'b0, USR_LOAD,  3'd0, 8'hFF, 1'b1, 1'b1, 8'h80});
    vecs.push_back('{1'b0, USR_LOAD,  3'd0, 8'hFF, 1'b1, 1'b1, 8'h80});
    vecs.push_back('{1'b1, USR_SHL,   3'd0, 8'hFF, 1'b1, 1'b1, 8'h80});
    vecs.push_back('{1'b1, USR_SHR,   3'd2, 8'h00, 1'b1, 1'b0, 8'hE0});
    vecs.push_back('{1'b1, USR_SHL,   3'd4, 8'h00, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, USR_LOAD,  3'd0, 8'h07, 1'b0, 1'b0, 8'h07});
    vecs.push_back('{1'b1, USR_CLEAR, 3'd5, 8'hFF, 1'b1, 1'b1, 8'h00});
    vecs.push_back('{1'b1, USR_LOAD,  3'd0, 8'hA5, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, USR_ASHR,  3'd1, 8'h00, 1'b0, 1'b0, 8'hD2});
    vecs.push_back('{1'b1, USR_ROTL,  3'd3, 8'h00, 1'b1, 1'b1, 8'h96});
    vecs.push_back('{1'b1, USR_ROTR,  3'd0, 8'h00, 1'b1, 1'b1, 8'h96});
    vecs.push_back('{1'b1, USR_HOLD,  3'd3, 8'hFF, 1'b1, 1'b1, 8'h96});
    vecs.push_back('{1'b1, USR_SHL,   3'd7, 8'h00, 1'b0, 1'b1, 8'h7F});
    vecs.push_back('{1'b1, USR_SHR,   3'd7, 8'h00, 1'b1, 1'b0, 8'hFE});
    vecs.push_back('{1'b1, USR_ASHR,  3'd7, 8'h00, 1'b0, 1'b0, 8'hFF});
    vecs.push_back('{1'b1, USR_LOAD,  3'd0, 8'h3C, 1'b0, 1'b0, 8'h3C});
    vecs.push_back('{1'b1, USR_ROTR,  3'd4, 8'h00, 1'b0, 1'b0, 8'hC3});

    // Reset before any clock edge: q cleared asynchronously.
    en = 1'b0; mode = 3'd0; amt = 3'd0; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_all("reset", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors through the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(vecs[i].exp_q);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL sb_empty: got none expected one entry");
      end else begin
        e = sb.pop_front();
        chk_all($sformatf("vec%0d", i), e);
      end
    end

    // Reset mid-cycle with q=A5 and a LOAD FF pending: cleared before the next edge.
    @(negedge clk);
    drive('{1'b1, USR_LOAD, 3'd0, 8'hA5, 1'b0, 1'b0, 8'hA5});
    @(posedge clk); #1;
    chk("pre_reset.q", q, 8'hA5);
    @(negedge clk);
    drive('{1'b1, USR_LOAD, 3'd0, 8'hFF, 1'b0, 1'b0, 8'hFF});
    #2 rst_n = 1'b0;
    #1 chk_all("mid_reset", 8'h00);
    @(posedge clk); #1;
    chk("reset_held.q", q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_release.q", q, 8'h00);
    @(posedge clk); #1;
    chk_all("first_update", 8'hFF);

    // Flush check: scoreboard must be drained.
    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 SHALL have parameter N, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  in  1  update enable; 0 = hold regardless of mode.
REQ-005 SHALL have port mode  in  3  operation select (encoding per REQ-012).
REQ-006 SHALL have port amt  in  $clog2(N)  shift/rotate amount, unsigned.
REQ-007 SHALL have port d  in  N  parallel load data.
REQ-008 SHALL have port sin_l  in  1  serial fill bit entering at MSB side.
REQ-009 SHALL have port sin_r  in  1  serial fill bit entering at LSB side.
REQ-010 SHALL have port q  out  N  register contents, driven directly from flops.
REQ-011 SHALL have ports sout_l, sout_r, zero, parity  out  1 each  q[N-1], q[0], (q==0), ^q; all combinational from q only.

Function
REQ-012 SHALL decode mode: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ASHR, 5 ROTL, 6 ROTR, 7 CLEAR.
REQ-013 SHALL, on rising clk with en=1, replace q with the mode result in the same edge; latency 1 cycle from input to q.
REQ-014 SHALL, with en=0 or mode=HOLD, keep q unchanged.
REQ-015 SHALL, for LOAD, set q to d; CLEAR sets q to 0; both ignore amt and serial inputs.
REQ-016 SHALL, for SHL by k=amt, shift left by k, filling the k LSBs with sin_r.
REQ-017 SHALL, for SHR by k, shift right by k, filling the k MSBs with sin_l.
REQ-018 SHALL, for ASHR by k, shift right by k, filling with the pre-shift q[N-1].
REQ-019 SHALL, for ROTL/ROTR, rotate by (amt mod N); no bits lost, serial inputs ignored.
REQ-020 SHALL, for SHL/SHR/ASHR with amt >= N (non-power-of-two N only), saturate to k=N: q becomes all fill bits.
REQ-021 SHALL treat amt=0 in any shift/rotate mode as HOLD.
REQ-022 SHALL derive all outputs from pre-edge q only; no combinational path from any input to any output.

Reset
REQ-023 SHALL, while rst_n=0, force q to 0 immediately and independent of clk, yielding sout_l=0, sout_r=0, zero=1, parity=0.
REQ-024 SHALL, on reset asserted mid-operation, discard the pending update; first post-reset update occurs on the first rising clk with rst_n=1.

Configuration
REQ-025 SHALL gate parity logic with macro USR_PARITY_EN: defined -> parity = XOR of q; undefined -> parity port present, tied to 0, no XOR logic synthesised.

Structure
REQ-026 SHALL place the mode encoding (enumerated typedef usr_mode_t) and mode constants in shared package usr_pkg.
REQ-027 SHALL implement the shift/rotate datapath as combinational sub-module usr_shifter (inputs q, mode, amt, sin_l, sin_r; output next value); top holds flops, mux and flags.

Verification (N=8)
REQ-028 SHALL cover: rst_n=0 mid-cycle with q=8'hA5 -> q=8'h00, zero=1 before next clk edge.
REQ-029 SHALL cover: LOAD d=8'h81, then SHL amt=1 sin_r=1 -> q=8'h03, sout_l=0, sout_r=1.
REQ-030 SHALL cover: q=8'h90, ASHR amt=3 -> q=8'hF2; SHR amt=3 sin_l=0 from 8'h90 -> q=8'h12.
REQ-031 SHALL cover: q=8'h81, ROTR amt=1 -> q=8'hC0; ROTL amt=7 from 8'h01 -> q=8'h80.
REQ-032 SHALL cover: en=0, mode=LOAD, d=8'hFF for 3 cycles -> q unchanged; amt=0 with SHL -> q unchanged.
REQ-033 SHALL cover: q=8'h07 -> parity=1 with USR_PARITY_EN defined, parity=0 when undefined.
